// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider, raster counters, pixel address out,
// and a one-pixel-delayed, mutually aligned DAC stage (colour, HS, VS, BLANK_N).
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] COLOUR_IN,
    output logic       PIX_TICK,
    output logic [9:0] ADDRH,
    output logic [8:0] ADDRV,
    output logic [7:0] COLOUR_OUT,
    output logic       HS,
    output logic       VS,
    output logic       BLANK_N,
    output logic       REFRESH
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_ACT_L      = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [9:0] V_ACT_L      = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_PRE_BLANK  = 10'(V_ACTIVE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [7:0]       colour_q, colour_d;
    logic             blank_n_q, blank_n_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             refresh_q, refresh_d;
    logic             pix_tick;
    logic             active0;

    always_comb begin
        pix_tick  = (div_q == DIV_LAST);
        div_d     = pix_tick ? '0 : div_q + 1'b1;
        active0   = (hcnt_q < H_ACT_L) && (vcnt_q < V_ACT_L);

        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        colour_d  = colour_q;
        blank_n_d = blank_n_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        refresh_d = 1'b0;

        // The DAC stage captures the pixel being addressed right now, so every
        // output it drives trails ADDRH/ADDRV by exactly one pixel.
        if (pix_tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end

            colour_d  = active0 ? COLOUR_IN : 8'h00;
            blank_n_d = active0;
            hs_d      = (hcnt_q >= H_SYNC_START && hcnt_q <= H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            vs_d      = (vcnt_q >= V_SYNC_START && vcnt_q <= V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            refresh_d = (hcnt_q == H_LAST) && (vcnt_q == V_PRE_BLANK);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q     <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            colour_q  <= 8'h00;
            blank_n_q <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            refresh_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            colour_q  <= colour_d;
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            refresh_q <= refresh_d;
        end
    end

    always_comb begin
        PIX_TICK   = pix_tick;
        ADDRH      = active0 ? hcnt_q : 10'd0;
        ADDRV      = active0 ? vcnt_q[8:0] : 9'd0;
        COLOUR_OUT = colour_q;
        HS         = hs_q;
        VS         = vs_q;
        BLANK_N    = blank_n_q;
        REFRESH    = refresh_q;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (default polarity / CLK_DIV=2 and
// inverted polarity / CLK_DIV=3) on a shrunken raster, each with its own scoreboard.
module tb_vga_timing_gen;

    localparam int HA    = 16;
    localparam int HFP   = 4;
    localparam int HSY   = 6;
    localparam int HBP   = 6;
    localparam int VA    = 12;
    localparam int VFP   = 2;
    localparam int VSY   = 2;
    localparam int VBP   = 3;
    localparam int HT    = HA + HFP + HSY + HBP;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       tick;
        logic [9:0] addrh;
        logic [8:0] addrv;
        logic [7:0] colour;
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic       refresh;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mask;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Expected outputs for the c-th CLK cycle after the last reset edge, worked out
    // purely from how many pixel ticks have elapsed since then.
    function automatic exp_t model_at(input int c, input int d, input logic pol, input logic [7:0] m);
        exp_t e;
        int   n, pos, h, v, prev, ph, pv;
        logic pa;
        n   = c / d;
        pos = n % FRAME;
        h   = pos % HT;
        v   = pos / HT;
        e.tick    = (c % d) == (d - 1);
        e.addrh   = (h < HA && v < VA) ? 10'(h) : 10'd0;
        e.addrv   = (h < HA && v < VA) ? 9'(v) : 9'd0;
        e.refresh = (c % d == 0) && (n > 0) && (pos == VA * HT);
        if (n == 0) begin
            e.colour  = 8'h00;
            e.blank_n = 1'b0;
            e.hs      = ~pol;
            e.vs      = ~pol;
        end else begin
            prev = (n - 1) % FRAME;
            ph   = prev % HT;
            pv   = prev / HT;
            pa   = (ph < HA) && (pv < VA);
            e.colour  = pa ? (8'(ph) ^ m) : 8'h00;
            e.blank_n = pa;
            e.hs      = (ph >= HA + HFP && ph < HA + HFP + HSY) ? pol : ~pol;
            e.vs      = (pv >= VA + VFP && pv < VA + VFP + VSY) ? pol : ~pol;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s[dut%0d]: got %0h expected %0h at %0t", name, idx, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input int rst_cycles, input int run_cycles);
        rst  = 1'b1;
        mask = 8'($urandom);
        repeat (rst_cycles) @(negedge clk);
        rst = 1'b0;
        repeat (run_cycles) @(negedge clk);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int   D   = (g == 0) ? 2 : 3;
        localparam logic POL = (g == 1);

        logic [7:0] colour_in  = 8'h00;
        logic [9:0] last_addrh = 10'd0;
        logic       pix_tick, hs, vs, blank_n, refresh;
        logic [9:0] addrh;
        logic [8:0] addrv;
        logic [7:0] colour_out;
        int         cyc = 0;
        exp_t       exp_q[$];
        exp_t       e;

        vga_timing_gen #(
            .CLK_DIV (D),
            .H_ACTIVE(HA),
            .H_FP    (HFP),
            .H_SYNC  (HSY),
            .H_BP    (HBP),
            .V_ACTIVE(VA),
            .V_FP    (VFP),
            .V_SYNC  (VSY),
            .V_BP    (VBP),
            .SYNC_POL(POL)
        ) dut (
            .CLK       (clk),
            .RESET     (rst),
            .COLOUR_IN (colour_in),
            .PIX_TICK  (pix_tick),
            .ADDRH     (addrh),
            .ADDRV     (addrv),
            .COLOUR_OUT(colour_out),
            .HS        (hs),
            .VS        (vs),
            .BLANK_N   (blank_n),
            .REFRESH   (refresh)
        );

        // Upstream lookup: garbage right after the address moves, then the
        // registered lookup value (address XOR a per-run mask) until the next move.
        always @(negedge clk) begin
            if (addrh !== last_addrh) colour_in = 8'($urandom);
            else                      colour_in = addrh[7:0] ^ mask;
            last_addrh = addrh;
        end

        always @(posedge clk) begin
            if (rst) cyc = 0;
            else     cyc = cyc + 1;
            exp_q.push_back(model_at(cyc, D, POL, mask));
        end

        always @(negedge clk) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL queue[dut%0d]: got empty expected entry at %0t", g, $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pix_tick", g, 32'(pix_tick), 32'(e.tick));
                checkOutput("addrh", g, 32'(addrh), 32'(e.addrh));
                checkOutput("addrv", g, 32'(addrv), 32'(e.addrv));
                checkOutput("colour_out", g, 32'(colour_out), 32'(e.colour));
                checkOutput("hs", g, 32'(hs), 32'(e.hs));
                checkOutput("vs", g, 32'(vs), 32'(e.vs));
                checkOutput("blank_n", g, 32'(blank_n), 32'(e.blank_n));
                checkOutput("refresh", g, 32'(refresh), 32'(e.refresh));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        mask = 8'($urandom);
        $display("[TB] starting vga_timing_gen bench");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME * 3 + 200) @(negedge clk);
        applyStimulus(1, $urandom_range(FRAME, 2 * FRAME));
        applyStimulus(1, 2 * FRAME * 3 + 100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom_range(1, 4), $urandom_range(100, 2 * FRAME * 3));
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
